// File: rtl/sisc_mem_pkg.sv
// sisc_mem_pkg: shared state/owner encodings and default widths for the SISC memory arbiter
package sisc_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/sisc_arb_prio.sv
// sisc_arb_prio: data-first winner select with a streak counter that guarantees fetch a slot
module sisc_arb_prio
  import sisc_mem_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic decide,
  output logic win_dm
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] streak;
  logic starved;
  always_comb begin
    starved = streak == SW'(STARVE_MAX);
    win_dm = dm_req && !(if_req && starved);
  end
  always_ff @(posedge clk) begin
    if (rst) streak <= '0;
    else if (decide) streak <= win_dm && if_req ? (starved ? streak : streak + SW'(1)) : '0;
  end
endmodule

// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: single-port memory sequencer sharing one memory between fetch and data requesters
module sisc_mem_arb
  import sisc_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  state_t state, state_n;
  logic own, we_l, decide, win_dm;
  logic [1:0] lat;
  sisc_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .dm_req(dm_req),
    .decide(decide),
    .win_dm(win_dm)
  );
  always_comb begin
    decide = state == IDLE && (if_req || dm_req);
    state_n = state == IDLE ? (decide ? ISSUE : IDLE)
      : state == ISSUE ? (we_l ? RESP : WAIT)
      : state == WAIT ? (lat == '0 ? RESP : WAIT)
      : IDLE;
    mem_en = state == ISSUE;
    mem_we = mem_en && we_l;
    if_gnt = mem_en && own == OWN_IF;
    dm_gnt = mem_en && own == OWN_DM;
    if_rvalid = state == RESP && own == OWN_IF;
    dm_done = state == RESP && own == OWN_DM;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own <= OWN_IF;
      we_l <= 1'b0;
      lat <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_n;
      if (decide) begin
        own <= win_dm ? OWN_DM : OWN_IF;
        we_l <= win_dm && dm_we;
        mem_addr <= win_dm ? dm_addr : if_addr;
        if (win_dm) mem_wdata <= dm_wdata;
      end
      if (state == ISSUE) lat <= 2'(MEM_LAT - 1);
      else if (state == WAIT) lat <= lat - 2'd1;
      if (state == WAIT && lat == '0) begin
        if (own == OWN_DM) dm_rdata <= mem_rdata;
        else if_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_sisc_mem_arb.sv
// tb_sisc_mem_arb: directed, corner-case and randomized checks of sisc_mem_arb at MEM_LAT 1 and 3
module tb_sisc_mem_arb;
  typedef struct {
    int k;
    bit f;
    bit we;
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic mem_init = 1'b0;
  logic rst [2];
  logic if_req [2];
  logic dm_req [2];
  logic dm_we [2];
  logic if_gnt [2];
  logic if_rvalid [2];
  logic dm_gnt [2];
  logic dm_done [2];
  logic mem_en [2];
  logic mem_we [2];
  logic busy [2];
  logic [15:0] if_addr [2];
  logic [15:0] dm_addr [2];
  logic [15:0] mem_addr [2];
  logic [31:0] dm_wdata [2];
  logic [31:0] if_rdata [2];
  logic [31:0] dm_rdata [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mmem [2][256];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a, ~a} ^ 32'h5A5A_1234;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : lane
    logic [31:0] mem [256];
    logic [15:0] ra;
    int since;
    sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(g ? 3 : 1), .STARVE_MAX(3)) dut (
      .clk(clk),
      .rst(rst[g]),
      .if_req(if_req[g]),
      .if_addr(if_addr[g]),
      .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata(if_rdata[g]),
      .dm_req(dm_req[g]),
      .dm_we(dm_we[g]),
      .dm_addr(dm_addr[g]),
      .dm_wdata(dm_wdata[g]),
      .dm_gnt(dm_gnt[g]),
      .dm_done(dm_done[g]),
      .dm_rdata(dm_rdata[g]),
      .mem_en(mem_en[g]),
      .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );
    always @(posedge clk) begin
      if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= pat(16'(i));
      else if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
      if (mem_en[g]) ra <= mem_addr[g];
      since <= mem_en[g] ? 1 : (since < 9 ? since + 1 : since);
    end
    assign mem_rdata[g] = since == (g ? 3 : 1) ? mem[ra[7:0]] : 32'hBADC_0DE0;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_one(input int k, input bit f, input bit we, input logic [15:0] a, input logic [31:0] wd,
                         output int g_at, output int d_at, output int en_n, output int we_n, output int busy_n);
    g_at = -1;
    d_at = -1;
    en_n = 0;
    we_n = 0;
    busy_n = 0;
    if (f) begin
      if_req[k] = 1'b1;
      if_addr[k] = a;
    end else begin
      dm_req[k] = 1'b1;
      dm_we[k] = we;
      dm_addr[k] = a;
      dm_wdata[k] = wd;
    end
    for (int c = 1; c <= 12 && d_at < 0; c++) begin
      @(negedge clk);
      if (busy[k]) busy_n++;
      if (mem_en[k]) en_n++;
      if (mem_we[k]) we_n++;
      if (f ? if_gnt[k] : dm_gnt[k]) begin
        g_at = c;
        if_req[k] = 1'b0;
        dm_req[k] = 1'b0;
      end
      if (f ? if_rvalid[k] : dm_done[k]) d_at = c;
    end
    if_req[k] = 1'b0;
    dm_req[k] = 1'b0;
    if (!f && we) mmem[k][a[7:0]] = wd;
    @(negedge clk);
  endtask
  task automatic rand_run(input int k, input int n);
    int lat, free_at, g_cyc, d_cyc, streak;
    bit own_dm, t_we, drop_if, drop_dm;
    logic [15:0] t_a;
    logic [31:0] t_d;
    logic [6:0] exp, act;
    lat = k ? 3 : 1;
    free_at = 0;
    g_cyc = -1;
    d_cyc = -1;
    streak = 0;
    own_dm = 1'b0;
    t_we = 1'b0;
    t_a = '0;
    t_d = '0;
    if_req[k] = 1'b0;
    dm_req[k] = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      exp = {c >= g_cyc && c <= d_cyc, c == g_cyc, c == g_cyc && t_we, c == g_cyc && !own_dm,
             c == g_cyc && own_dm, c == d_cyc && !own_dm, c == d_cyc && own_dm};
      act = {busy[k], mem_en[k], mem_we[k], if_gnt[k], dm_gnt[k], if_rvalid[k], dm_done[k]};
      chk("rand_ctl", act, exp);
      if (c == g_cyc) begin
        chk("rand_addr", mem_addr[k], t_a);
        if (t_we) chk("rand_wdata", mem_wdata[k], t_d);
      end
      if (c == d_cyc && !t_we) chk("rand_rdata", own_dm ? dm_rdata[k] : if_rdata[k], t_d);
      drop_if = c == g_cyc && !own_dm;
      drop_dm = c == g_cyc && own_dm;
      if (drop_if) if_req[k] = 1'b0;
      if (drop_dm) dm_req[k] = 1'b0;
      if (!drop_if && !if_req[k] && $urandom_range(2) == 0) begin
        if_req[k] = 1'b1;
        if_addr[k] = 16'($urandom_range(15));
      end
      if (!drop_dm && !dm_req[k] && $urandom_range(2) == 0) begin
        dm_req[k] = 1'b1;
        dm_we[k] = 1'($urandom_range(1));
        dm_addr[k] = 16'($urandom_range(15));
        dm_wdata[k] = $urandom;
      end
      if (c >= free_at && (if_req[k] || dm_req[k])) begin
        own_dm = dm_req[k] && !(if_req[k] && streak == 3);
        streak = own_dm && if_req[k] ? streak + 1 : 0;
        t_we = own_dm && dm_we[k];
        t_a = own_dm ? dm_addr[k] : if_addr[k];
        g_cyc = c + 1;
        d_cyc = t_we ? c + 2 : c + 2 + lat;
        free_at = d_cyc + 1;
        if (t_we) begin
          t_d = dm_wdata[k];
          mmem[k][t_a[7:0]] = t_d;
        end else t_d = mmem[k][t_a[7:0]];
      end
    end
    if_req[k] = 1'b0;
    dm_req[k] = 1'b0;
  endtask
  initial begin
    vec_t v [8];
    int g_at, d_at, en_n, we_n, busy_n, n, gi;
    bit ord [8];
    bit exp_ord [8];
    v[0] = '{0, 1'b0, 1'b1, 16'h0020, 32'h1234_5678, 32'h0, 2};
    v[1] = '{0, 1'b0, 1'b0, 16'h0020, 32'h0, 32'h1234_5678, 3};
    v[2] = '{0, 1'b0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 32'h0, 2};
    v[3] = '{0, 1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 3};
    v[4] = '{0, 1'b1, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 3};
    v[5] = '{1, 1'b0, 1'b1, 16'h0004, 32'h8000_0001, 32'h0, 2};
    v[6] = '{1, 1'b1, 1'b0, 16'h0004, 32'h0, 32'h8000_0001, 5};
    v[7] = '{1, 1'b0, 1'b0, 16'h0030, 32'h0, 32'h5A5A_1234 ^ 32'h0030_FFCF, 5};
    exp_ord = '{1, 1, 1, 0, 1, 1, 1, 0};
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      if_req[k] = 1'b0;
      dm_req[k] = 1'b0;
      dm_we[k] = 1'b0;
      if_addr[k] = '0;
      dm_addr[k] = '0;
      dm_wdata[k] = '0;
      for (int i = 0; i < 256; i++) mmem[k][i] = pat(16'(i));
    end
    mem_init = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ctl", {busy[k], mem_en[k], mem_we[k], if_gnt[k], dm_gnt[k], if_rvalid[k], dm_done[k]}, 0);
      chk("rst_addr", mem_addr[k], 0);
      chk("rst_wdata", mem_wdata[k], 0);
      chk("rst_rdata", {if_rdata[k], dm_rdata[k]}, 0);
    end
    mem_init = 1'b0;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      run_one(v[i].k, v[i].f, v[i].we, v[i].a, v[i].wd, g_at, d_at, en_n, we_n, busy_n);
      chk($sformatf("v%0d_gnt_at", i), 64'(g_at), 1);
      chk($sformatf("v%0d_done_at", i), 64'(d_at), 64'(v[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'(v[i].lat));
      chk($sformatf("v%0d_mem_en_cycles", i), 64'(en_n), 1);
      chk($sformatf("v%0d_mem_we_cycles", i), 64'(we_n), 64'(v[i].we));
      if (!v[i].we) chk($sformatf("v%0d_rdata", i), v[i].f ? if_rdata[v[i].k] : dm_rdata[v[i].k], v[i].exp);
    end
    chk("if_rdata_hold", if_rdata[1], 32'h8000_0001);
    if_req[0] = 1'b1;
    if_addr[0] = 16'h0010;
    dm_req[0] = 1'b1;
    dm_we[0] = 1'b0;
    dm_addr[0] = 16'h0020;
    gi = 0;
    for (int c = 0; c < 80 && gi < 8; c++) begin
      @(negedge clk);
      if (if_gnt[0] || dm_gnt[0]) begin
        ord[gi] = dm_gnt[0];
        gi++;
      end
    end
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    chk("contend_grants", 64'(gi), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("contend_order%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
    for (int c = 0; c < 20 && busy[0]; c++) @(negedge clk);
    chk("contend_drain", 64'(busy[0]), 0);
    if_req[1] = 1'b1;
    if_addr[1] = 16'h0004;
    @(negedge clk);
    chk("rw_gnt", 64'(if_gnt[1]), 1);
    if_req[1] = 1'b0;
    @(negedge clk);
    chk("rw_busy", 64'(busy[1]), 1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rw_ctl", {busy[1], mem_en[1], mem_we[1], if_gnt[1], dm_gnt[1], if_rvalid[1], dm_done[1]}, 0);
    chk("rw_rdata", {if_rdata[1], dm_rdata[1]}, 0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_rvalid[1] || dm_done[1] || busy[1] || mem_en[1]) n++;
    end
    chk("rw_quiet", 64'(n), 0);
    run_one(1, 1'b1, 1'b0, 16'h0004, 32'h0, g_at, d_at, en_n, we_n, busy_n);
    chk("rw_fresh_gnt", 64'(g_at), 1);
    chk("rw_fresh_done", 64'(d_at), 5);
    chk("rw_fresh_rdata", if_rdata[1], 32'h8000_0001);
    rand_run(0, 400);
    rand_run(1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sisc_mem_arb.md
# sisc_mem_arb

Single-port memory arbiter/sequencer for the SISC core. It shares one unified instruction/data memory port between the instruction-fetch requester (driven during `fetch`) and the data requester (LOD/STR during `mem`). Data accesses have priority, and a bounded-starvation guard protects fetch. It allows one outstanding transaction and sequences the memory's fixed read latency.

## Interface
- `AW`, 16: address width (matches 16-bit effective-address mux).
- `DW`, 32: data width.
- `MEM_LAT`, 1: memory read latency in cycles; legal values 1–4.
- `STARVE_MAX`, 3: max consecutive data grants while fetch is waiting.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in AW: fetch address; stable while `if_req`.
- `if_gnt` out 1: one-cycle pulse when fetch is issued to memory.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out DW: fetched word; holds until next fetch completes.
- `dm_req` in 1: data request; held until `dm_gnt`.
- `dm_we` in 1: 1 = store, 0 = load; stable with `dm_req`.
- `dm_addr` in AW: data address.
- `dm_wdata` in DW: store data.
- `dm_gnt` out 1: one-cycle pulse at issue.
- `dm_done` out 1: one-cycle pulse; load data valid or store committed.
- `dm_rdata` out DW: load word; holds until next load completes.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: valid in cycle (issue + MEM_LAT).
- `busy` out 1: high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - No request: stay in IDLE.
  - Any request: choose a winner; latch owner, address, we, wdata; go to ISSUE.
- **Winner selection**
  - Only one requester active: it wins.
  - Both active: data wins, unless `streak == STARVE_MAX`; then fetch wins.
- **streak counter** (saturating, width clog2(STARVE_MAX+1))
  - Increments on a data win with `if_req` high.
  - Clears on a fetch win.
  - Clears on a data win with `if_req` low.
- **ISSUE**
  - Drives `mem_en`=1, `mem_addr`/`mem_we`/`mem_wdata` from latches.
  - Pulses the owner's gnt.
  - Fetch is always read-only (`mem_we`=0).
  - Write goes to RESP; read goes to WAIT with the latency counter = MEM_LAT−1.
- **WAIT**
  - Counter decrements each cycle.
  - At counter 0, `mem_rdata` is captured into the owner's rdata register; go to RESP.
- **RESP**
  - Pulses `if_rvalid` or `dm_done` for the owner; go to IDLE.
- **Outside ISSUE:** `mem_en`=0 and `mem_we`=0; `mem_addr`/`mem_wdata` hold their last values.
- **Reset** (any state, including mid-transaction):
  - State returns to IDLE with no completion pulse.
  - streak=0.
  - All pulses, `mem_en`, `mem_we`, and `busy` are 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` are 0.
- **Protocol violation:** a requester dropping req before gnt is illegal. The block ignores the drop and completes the latched request.

## Timing
- Request first seen in IDLE at cycle t:
  - ISSUE/gnt at t+1.
  - Read: WAIT t+2 .. t+1+MEM_LAT; rvalid/done at t+2+MEM_LAT; IDLE at t+3+MEM_LAT.
  - Write: done at t+2; IDLE at t+3.
- Requests asserted while busy are evaluated in the first IDLE cycle; there is no queueing.
- Simultaneous requests in IDLE resolve per the priority rule; the loser's gnt stays 0 and it is served on the next IDLE.
- Requester may deassert req in the cycle after gnt and reassert at any later cycle.

## Structure
- Package `sisc_mem_pkg`:
  - State encoding constants (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - Owner constants (OWN_IF=0, OWN_DM=1).
  - Default AW/DW.
- Sub-module `sisc_arb_prio`:
  - Combinational winner select plus registered streak counter.
  - Ports: `clk`, `rst`, `if_req`, `dm_req`, `decide`, `win_dm`.
- Top holds the FSM, latency counter, latches, and response registers.

## Test plan
- Lone load, MEM_LAT=1: `dm_req`, `dm_addr`=0x0010, mem word 0xDEADBEEF → `dm_gnt` at t+1; `dm_done` at t+3 with `dm_rdata`=0xDEADBEEF; `busy` high t+1..t+3.
- Lone store: `dm_we`=1, addr 0x0020, wdata 0x12345678 → `mem_en`=`mem_we`=1 at t+1 only; `dm_done` at t+2; readback load returns 0x12345678.
- Contention, STARVE_MAX=3: `if_req` and `dm_req` held continuously → grant order DM, DM, DM, IF, DM, DM, DM, IF.
- MEM_LAT=3 fetch: addr 0x0004, word 0x8000_0001 → `if_gnt` t+1; `if_rvalid` t+5 with the word; `if_rdata` unchanged after later data loads.
- Reset during WAIT: `rst`=1 for one cycle → next cycle IDLE; no `if_rvalid`/`dm_done`; `mem_en`=0; rdata registers 0; a fresh request completes normally.
